// File: rtl/conv_pkg.sv
// Shared types and sizing for the conv engine frame scheduler.
package conv_pkg;

   localparam int IMG_W     = 32;
   localparam int IMG_H     = 32;
   localparam int K         = 5;
   localparam int NUM_FMAPS = 6;
   localparam int PIX_W     = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } conv_sched_state_t;

endpackage

// File: rtl/conv_frame_sched_if.sv
// Scheduler control, image BRAM read port, conv pixel stream and conv result strobes.
interface conv_frame_sched_if #(
   parameter int ADDR_W = 10
);
   import conv_pkg::*;

   logic              i_start;
   logic              o_busy;
   logic              o_done;
   logic              o_err;
   logic              o_img_en;
   logic [ADDR_W-1:0] o_img_addr;
   logic [PIX_W-1:0]  i_img_data;
   logic              o_feature_valid;
   logic [PIX_W-1:0]  o_feature;
   logic              i_feature_ready;
   logic              i_conv_valid;
   logic              i_conv_last;
   logic [15:0]       o_out_count;

   modport master (
      input  i_start,
      input  i_img_data,
      input  i_feature_ready,
      input  i_conv_valid,
      input  i_conv_last,
      output o_busy,
      output o_done,
      output o_err,
      output o_img_en,
      output o_img_addr,
      output o_feature_valid,
      output o_feature,
      output o_out_count
   );

   modport slave (
      output i_start,
      output i_img_data,
      output i_feature_ready,
      output i_conv_valid,
      output i_conv_last,
      input  o_busy,
      input  o_done,
      input  o_err,
      input  o_img_en,
      input  o_img_addr,
      input  o_feature_valid,
      input  o_feature,
      input  o_out_count
   );

endinterface

// File: rtl/conv_prefetch_fifo.sv
// Two-entry pixel prefetch buffer with a registered head and flush.
module conv_prefetch_fifo
   import conv_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] head,
   output logic [1:0]       occ
);

   logic [PIX_W-1:0] tail;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_pop  = pop && (occ != 2'd0);
      do_push = push && ((occ != 2'd2) || do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ  <= 2'd0;
         head <= '0;
         tail <= '0;
      end else if (flush) begin
         occ <= 2'd0;
      end else begin
         unique case ({do_push, do_pop})
            2'b10: begin
               if (occ == 2'd0) head <= din;
               else             tail <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; the new pixel lands behind the old tail
               if (occ == 2'd1) begin
                  head <= din;
               end else begin
                  head <= tail;
                  tail <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/conv_frame_sched.sv
// Frame scheduler: streams one image from BRAM into conv and checks conv output beats.
module conv_frame_sched #(
   parameter int IMG_W  = conv_pkg::IMG_W,
   parameter int IMG_H  = conv_pkg::IMG_H,
   parameter int K      = conv_pkg::K,
   parameter int ADDR_W = 10
) (
   input logic                i_clk,
   input logic                i_rst_n,
   conv_frame_sched_if.master bus
);
   import conv_pkg::*;

   localparam int OUT_W = IMG_W - K + 1;
   localparam int OUT_H = IMG_H - K + 1;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int NOUT  = OUT_W * OUT_H;
   localparam int PTR_W = $clog2(NPIX + 1);

   conv_sched_state_t state_q;
   conv_sched_state_t state_d;

   logic [PTR_W-1:0] rd_ptr_q;
   logic             inflight_q;
   logic             last_seen_q;
   logic             err_q;
   logic [15:0]      out_count_q;

   logic [1:0]       occ;
   logic [PIX_W-1:0] head;

   logic       streaming;
   logic       active;
   logic       fifo_valid;
   logic       pop;
   logic       push;
   logic       issue;
   logic       ptr_end;
   logic       is_final;
   logic       bad_beat;
   logic       final_ok;
   logic       last_xfer;
   logic       start_ok;
   logic       flush;
   logic [2:0] pending;

   always_comb begin
      streaming  = state_q == S_STREAM;
      active     = streaming || (state_q == S_DRAIN);
      fifo_valid = occ != 2'd0;
      pop        = fifo_valid && bus.i_feature_ready;
      push       = inflight_q && streaming;
      ptr_end    = rd_ptr_q == PTR_W'(NPIX);
      is_final   = out_count_q == 16'(NOUT - 1);
      bad_beat   = bus.i_conv_valid &&
                   (!active || last_seen_q || (bus.i_conv_last != is_final));
      final_ok   = bus.i_conv_valid && active && !bad_beat && is_final;
      // a slot freed by this cycle's pop may be refilled at once
      pending    = {1'b0, occ} + {2'b00, inflight_q};
      issue      = streaming && !bad_beat && !ptr_end &&
                   (pending < (3'd2 + {2'b00, pop}));
      last_xfer  = streaming && pop && ptr_end && !inflight_q && (occ == 2'd1);
      start_ok   = (state_q == S_IDLE) && bus.i_start && !bad_beat;
      flush      = bad_beat || start_ok;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_ok) state_d = S_STREAM;
         end
         S_STREAM: begin
            if (bad_beat)
               state_d = S_IDLE;
            else if (last_xfer)
               state_d = (last_seen_q || final_ok) ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            if (bad_beat)      state_d = S_IDLE;
            else if (final_ok) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr_q    <= '0;
         inflight_q  <= 1'b0;
         last_seen_q <= 1'b0;
         err_q       <= 1'b0;
         out_count_q <= '0;
      end else begin
         inflight_q <= issue;
         err_q      <= bad_beat;
         if (start_ok) begin
            rd_ptr_q    <= '0;
            last_seen_q <= 1'b0;
            out_count_q <= '0;
         end else begin
            if (issue)
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (bus.i_conv_valid && active && (out_count_q != 16'hFFFF))
               out_count_q <= out_count_q + 16'd1;
            // final beat seen while pixels remain: finish once they drain
            if (final_ok && streaming)
               last_seen_q <= 1'b1;
         end
      end
   end

   conv_prefetch_fifo u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (bus.i_img_data),
      .head  (head),
      .occ   (occ)
   );

   assign bus.o_busy          = active;
   assign bus.o_done          = state_q == S_DONE;
   assign bus.o_err           = err_q;
   assign bus.o_img_en        = issue;
   assign bus.o_img_addr      = ADDR_W'(rd_ptr_q);
   assign bus.o_feature_valid = fifo_valid;
   assign bus.o_feature       = head;
   assign bus.o_out_count     = out_count_q;

endmodule

// File: tb/tb_conv_frame_sched.sv
// Directed bench for conv_frame_sched with a BRAM model and a pixel-stream monitor.
module tb_conv_frame_sched;

   logic clk;
   logic rst_n;

   conv_frame_sched_if #(.ADDR_W(10)) bus();

   conv_frame_sched #(
      .IMG_W  (32),
      .IMG_H  (32),
      .K      (5),
      .ADDR_W (10)
   ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   int xfer      = 0;
   int pix_err   = 0;
   int stall_err = 0;
   int err_n     = 0;
   int done_n    = 0;
   int cyc_n     = 0;
   int first_cyc = 0;
   int last_cyc  = 0;
   bit busy_p    = 0;
   bit stall_p   = 0;
   logic [7:0] feat_p = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // image BRAM holds addr[7:0], one cycle read latency
   always @(posedge clk)
      if (bus.o_img_en) bus.i_img_data <= bus.o_img_addr[7:0];

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_p  = 1'b0;
         stall_p = 1'b0;
      end else begin
         if (bus.o_busy && !busy_p) xfer = 0;
         busy_p = bus.o_busy;
         if (stall_p && (!bus.o_feature_valid || bus.o_feature != feat_p))
            stall_err++;
         if (bus.o_feature_valid && bus.i_feature_ready) begin
            if (bus.o_feature != 8'(xfer)) pix_err++;
            if (xfer == 0) first_cyc = cyc_n;
            last_cyc = cyc_n;
            xfer++;
         end
         stall_p = bus.o_feature_valid && !bus.i_feature_ready;
         feat_p  = bus.o_feature;
         if (bus.o_err)  err_n++;
         if (bus.o_done) done_n++;
      end
      cyc_n++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc_drive(input bit rdy, input bit cv, input bit cl, input bit st);
      bus.i_feature_ready = rdy;
      bus.i_conv_valid    = cv;
      bus.i_conv_last     = cl;
      bus.i_start         = st;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  beats;
      int  k;
      int  e0;
      int  d0;
      bit  cv;
      bit  cl;
      bit  rdy;

      rst_n               = 1'b0;
      bus.i_start         = 1'b0;
      bus.i_feature_ready = 1'b0;
      bus.i_conv_valid    = 1'b0;
      bus.i_conv_last     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  bus.o_busy, 0);
      chk("rst_done",  bus.o_done, 0);
      chk("rst_err",   bus.o_err, 0);
      chk("rst_en",    bus.o_img_en, 0);
      chk("rst_valid", bus.o_feature_valid, 0);
      chk("rst_feat",  bus.o_feature, 0);
      chk("rst_count", bus.o_out_count, 0);
      chk("rst_addr",  bus.o_img_addr, 0);
      rst_n = 1'b1;
      cyc_drive(0, 0, 0, 0);

      // full frame, ready high, final beat in DRAIN
      e0 = err_n;
      d0 = done_n;
      cyc_drive(1, 0, 0, 1);
      chk("t1_busy",    bus.o_busy, 1);
      chk("t1_cnt_clr", bus.o_out_count, 0);
      chk("t1_rd_en",   bus.o_img_en, 1);
      chk("t1_addr0",   bus.o_img_addr, 0);
      cyc_drive(1, 0, 0, 0);
      chk("t1_valid_lat1", bus.o_feature_valid, 0);
      cyc_drive(1, 0, 0, 0);
      chk("t1_valid_lat2", bus.o_feature_valid, 1);
      chk("t1_first_pix",  bus.o_feature, 0);
      beats = 0;
      k     = 0;
      while (!bus.o_done && k < 3000) begin
         cv = 1'b0;
         cl = 1'b0;
         if (beats < 783 && xfer >= 200) begin
            cv = 1'b1;
         end else if (beats == 783 && xfer == 1024) begin
            cv = 1'b1;
            cl = 1'b1;
            chk("t3_drain_busy", bus.o_busy, 1);
         end
         cyc_drive(1, cv, cl, 0);
         beats += int'(cv);
         k++;
      end
      chk("t3_done",      bus.o_done, 1);
      chk("t3_count",     bus.o_out_count, 784);
      chk("t3_busy_fall", bus.o_busy, 0);
      chk("t1_xfers",     xfer, 1024);
      chk("t1_no_gap",    last_cyc - first_cyc, 1023);
      cyc_drive(1, 0, 0, 0);
      chk("t3_done_1cyc", bus.o_done, 0);
      chk("t3_done_once", done_n - d0, 1);
      chk("t3_no_err",    err_n - e0, 0);
      chk("t1_pix_order", pix_err, 0);

      // ready 1,0,0,1 with the final beat arriving mid-stream
      e0 = err_n;
      cyc_drive(1, 0, 0, 1);
      cyc_drive(1, 0, 0, 0);
      beats = 0;
      k     = 0;
      while (!bus.o_done && k < 8000) begin
         rdy = (k % 4 == 0) || (k % 4 == 3);
         cv  = (beats < 784) && (xfer >= 100);
         cl  = cv && (beats == 783);
         cyc_drive(rdy, cv, cl, 0);
         beats += int'(cv);
         k++;
         if (cl) begin
            chk("t6_early_busy", bus.o_busy, 1);
            chk("t6_pixels_left", (xfer < 1024) ? 1 : 0, 1);
         end
      end
      chk("t6_done",       bus.o_done, 1);
      chk("t6_all_pixels", xfer, 1024);
      chk("t6_count",      bus.o_out_count, 784);
      chk("t6_no_err",     err_n - e0, 0);
      chk("t2_stall_hold", stall_err, 0);
      chk("t2_pix_order",  pix_err, 0);
      cyc_drive(0, 0, 0, 0);

      // early last flag on beat 100
      cyc_drive(1, 0, 0, 1);
      for (int i = 0; i < 100; i++) cyc_drive(1, 1, i == 99, 0);
      chk("t4_err",   bus.o_err, 1);
      chk("t4_count", bus.o_out_count, 100);
      chk("t4_busy",  bus.o_busy, 0);
      chk("t4_valid", bus.o_feature_valid, 0);
      chk("t4_done",  bus.o_done, 0);
      cyc_drive(1, 0, 0, 0);
      chk("t4_err_1cyc",   bus.o_err, 0);
      chk("t4_valid_next", bus.o_feature_valid, 0);

      // conv beat while idle
      cyc_drive(0, 1, 0, 0);
      chk("idle_beat_err", bus.o_err, 1);
      chk("idle_beat_cnt", bus.o_out_count, 100);
      cyc_drive(0, 0, 0, 0);

      // restart ignored mid-stream, then reset at pixel 500
      cyc_drive(1, 0, 0, 1);
      for (int i = 0; i < 40; i++) cyc_drive(1, i < 10, 0, 0);
      chk("t5_count", bus.o_out_count, 10);
      cyc_drive(1, 0, 0, 1);
      chk("t5_restart_busy", bus.o_busy, 1);
      chk("t5_restart_cnt",  bus.o_out_count, 10);
      k = 0;
      while (xfer < 500 && k < 2000) begin
         cyc_drive(1, 0, 0, 0);
         k++;
      end
      chk("t5_reach500", xfer, 500);
      rst_n = 1'b0;
      #2;
      chk("t5_rst_flags", {bus.o_busy, bus.o_done, bus.o_err,
                           bus.o_img_en, bus.o_feature_valid}, 0);
      chk("t5_rst_feat",  bus.o_feature, 0);
      chk("t5_rst_count", bus.o_out_count, 0);
      chk("t5_rst_addr",  bus.o_img_addr, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc_drive(1, 0, 0, 0);
      chk("t5_idle_valid", bus.o_feature_valid, 0);
      cyc_drive(1, 0, 0, 1);
      chk("t5_new_en",   bus.o_img_en, 1);
      chk("t5_new_addr", bus.o_img_addr, 0);
      repeat (20) cyc_drive(1, 0, 0, 0);
      chk("t5_new_pixels", (xfer > 0) ? 1 : 0, 1);
      chk("t5_pix_order",  pix_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
